// File: rtl/pl_stage_reg.sv
// Pipeline stage register carrying {pc, instr} with valid/ready handshake, flush,
// optional 2-entry skid buffer (registered o_ready) and a saturating stall counter.
module pl_stage_reg #(
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          INSTR_W   = 32,
  parameter int unsigned          SKID      = 1,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(32'h00000013),
  parameter int unsigned          CNT_W     = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [PC_W-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [CNT_W-1:0]   o_stall_cnt
);

  logic               valid;
  logic [PC_W-1:0]    held_pc;
  logic [INSTR_W-1:0] held_instr;
  logic               accept;
  logic               drain;
  logic [CNT_W-1:0]   stall_cnt_reg;

  assign accept = i_valid & o_ready;
  assign drain  = valid & i_ready;

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
      } state_t;

      state_t             state_reg, state_next;
      logic [PC_W-1:0]    main_pc_reg, main_pc_next;
      logic [INSTR_W-1:0] main_instr_reg, main_instr_next;
      logic [PC_W-1:0]    skid_pc_reg, skid_pc_next;
      logic [INSTR_W-1:0] skid_instr_reg, skid_instr_next;
      logic               ready_reg, ready_next;

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          state_reg      <= EMPTY;
          main_pc_reg    <= '0;
          main_instr_reg <= NOP_INSTR;
          skid_pc_reg    <= '0;
          skid_instr_reg <= NOP_INSTR;
          ready_reg      <= 1'b1;
        end else begin
          state_reg      <= state_next;
          main_pc_reg    <= main_pc_next;
          main_instr_reg <= main_instr_next;
          skid_pc_reg    <= skid_pc_next;
          skid_instr_reg <= skid_instr_next;
          ready_reg      <= ready_next;
        end
      end

      always_comb begin
        state_next      = state_reg;
        main_pc_next    = main_pc_reg;
        main_instr_next = main_instr_reg;
        skid_pc_next    = skid_pc_reg;
        skid_instr_next = skid_instr_reg;

        case (state_reg)
          EMPTY: begin
            if (accept) begin
              main_pc_next    = i_pc;
              main_instr_next = i_instr;
              state_next      = FULL1;
            end
          end
          FULL1: begin
            if (accept && drain) begin
              main_pc_next    = i_pc;
              main_instr_next = i_instr;
            end else if (accept) begin
              skid_pc_next    = i_pc;
              skid_instr_next = i_instr;
              state_next      = FULL2;
            end else if (drain) begin
              state_next = EMPTY;
            end
          end
          FULL2: begin
            // o_ready is low here, so any i_valid is simply not accepted.
            if (drain) begin
              main_pc_next    = skid_pc_reg;
              main_instr_next = skid_instr_reg;
              state_next      = FULL1;
            end
          end
          default: state_next = EMPTY;
        endcase

        // Flush overrides everything; a same-cycle drain has already been seen downstream.
        if (i_flush) begin
          state_next      = EMPTY;
          main_pc_next    = '0;
          main_instr_next = NOP_INSTR;
          skid_pc_next    = '0;
          skid_instr_next = NOP_INSTR;
        end

        ready_next = (state_next != FULL2);
      end

      assign o_ready    = ready_reg;
      assign valid      = (state_reg != EMPTY);
      assign held_pc    = main_pc_reg;
      assign held_instr = main_instr_reg;
    end else begin : g_single
      logic               valid_reg;
      logic [PC_W-1:0]    pc_reg;
      logic [INSTR_W-1:0] instr_reg;

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          valid_reg <= 1'b0;
          pc_reg    <= '0;
          instr_reg <= NOP_INSTR;
        end else if (i_flush) begin
          valid_reg <= 1'b0;
          pc_reg    <= '0;
          instr_reg <= NOP_INSTR;
        end else if (accept) begin
          valid_reg <= 1'b1;
          pc_reg    <= i_pc;
          instr_reg <= i_instr;
        end else if (drain) begin
          valid_reg <= 1'b0;
        end
      end

      assign o_ready    = i_ready | ~valid_reg;
      assign valid      = valid_reg;
      assign held_pc    = pc_reg;
      assign held_instr = instr_reg;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt_reg <= '0;
    end else if (valid && !i_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign o_valid     = valid;
  assign o_pc        = held_pc;
  assign o_instr     = valid ? held_instr : NOP_INSTR;
  assign o_stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pl_stage_reg.sv
// Scoreboard bench for pl_stage_reg: a skid instance and a single-entry instance
// share stimulus; each is compared with a queue model of its held entries.
module tb_pl_stage_reg;
  localparam int          PC_W    = 32;
  localparam int          INSTR_W = 32;
  localparam int          CNT_W   = 4;
  localparam logic [31:0] NOP     = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_flush = 1'b0;
  logic i_valid = 1'b0;
  logic i_ready = 1'b0;
  logic [PC_W-1:0]    i_pc = '0;
  logic [INSTR_W-1:0] i_instr = '0;

  logic               o_ready [2];
  logic               o_valid [2];
  logic [PC_W-1:0]    o_pc [2];
  logic [INSTR_W-1:0] o_instr [2];
  logic [CNT_W-1:0]   o_stall_cnt [2];

  entry_t      sb [2][$];
  logic [31:0] last_pc [2];
  int          stall_m [2];
  bit          exp_ready [2];
  int          checks = 0;
  int          passes = 0;

  always #5 i_clk = ~i_clk;

  pl_stage_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .SKID(1), .NOP_INSTR(NOP), .CNT_W(CNT_W)) u_skid (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready[0]),
    .i_pc(i_pc), .i_instr(i_instr), .o_valid(o_valid[0]), .i_ready(i_ready),
    .o_pc(o_pc[0]), .o_instr(o_instr[0]), .o_stall_cnt(o_stall_cnt[0])
  );

  pl_stage_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .SKID(0), .NOP_INSTR(NOP), .CNT_W(CNT_W)) u_single (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready[1]),
    .i_pc(i_pc), .i_instr(i_instr), .o_valid(o_valid[1]), .i_ready(i_ready),
    .o_pc(o_pc[1]), .o_instr(o_instr[1]), .o_stall_cnt(o_stall_cnt[1])
  );

  task automatic chk(input int d, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL dut%0d %s: got %h expected %h (t=%0t)", d, what, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      sb[d].delete();
      last_pc[d] = '0;
      stall_m[d] = 0;
    end
  endtask

  // Monitor: compares outputs mid-cycle and retires entries that drain at the next edge.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      for (int d = 0; d < 2; d++) begin
        automatic bit ev = (sb[d].size() != 0);
        automatic bit er = (d == 0) ? (sb[d].size() < 2) : (i_ready || !ev);
        exp_ready[d] = er;
        chk(d, "o_valid", 32'(o_valid[d]), 32'(ev));
        chk(d, "o_ready", 32'(o_ready[d]), 32'(er));
        chk(d, "o_stall_cnt", 32'(o_stall_cnt[d]), 32'(stall_m[d]));
        if (ev) begin
          chk(d, "o_pc", o_pc[d], sb[d][0].pc);
          chk(d, "o_instr", o_instr[d], sb[d][0].instr);
        end else begin
          chk(d, "o_pc idle", o_pc[d], last_pc[d]);
          chk(d, "o_instr idle", o_instr[d], NOP);
        end
        if (ev && i_ready) begin
          automatic entry_t e = sb[d].pop_front();
          last_pc[d] = e.pc;
          $display("dut%0d drain pc=%h instr=%h t=%0t", d, e.pc, e.instr, $time);
        end
        if (ev && !i_ready && stall_m[d] < 15) stall_m[d]++;
      end
    end
  end

  // Stimulus-side commit: entries accepted this cycle are queued as expectations.
  always @(negedge i_clk) begin
    #1;
    if (!i_reset) begin
      for (int d = 0; d < 2; d++) begin
        if (i_flush) begin
          sb[d].delete();
          last_pc[d] = '0;
        end else if (i_valid && exp_ready[d]) begin
          sb[d].push_back(entry_t'{pc: i_pc, instr: i_instr});
        end
      end
    end
  end

  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                      input bit rdy, input bit fl);
    @(posedge i_clk);
    #1;
    i_valid = v;
    i_pc    = v ? pc : 'x;
    i_instr = v ? instr : 'x;
    i_ready = rdy;
    i_flush = fl;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, rdy, 1'b0);
  endtask

  initial begin
    model_reset();
    exp_ready[0] = 1'b1;
    exp_ready[1] = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    idle(2, 1'b1);

    // Streaming
    step(1'b1, 32'h0, 32'hAAAA_0001, 1'b1, 1'b0);
    step(1'b1, 32'h4, 32'hBBBB_0002, 1'b1, 1'b0);
    step(1'b1, 32'h8, 32'hCCCC_0003, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Skid fill, stall, then drain
    step(1'b1, 32'h10, 32'h1111_0010, 1'b1, 1'b0);
    step(1'b1, 32'h14, 32'h1111_0014, 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(3, 1'b1);

    // Flush while both entries are held
    step(1'b1, 32'h30, 32'h3333_0030, 1'b1, 1'b0);
    step(1'b1, 32'h34, 32'h3333_0034, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Flush beats a simultaneous accept
    step(1'b1, 32'h20, 32'h2222_0020, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Counter saturation
    step(1'b1, 32'h40, 32'h4444_0040, 1'b0, 1'b0);
    idle(21, 1'b0);
    @(negedge i_clk);
    chk(0, "stall saturation", 32'(o_stall_cnt[0]), 32'd15);
    idle(3, 1'b1);

    // Asynchronous reset in the middle of a cycle while two entries are held
    step(1'b1, 32'h50, 32'h5555_0050, 1'b1, 1'b0);
    step(1'b1, 32'h54, 32'h5555_0054, 1'b0, 1'b0);
    idle(1, 1'b0);
    @(posedge i_clk);
    #3;
    i_valid = 1'b0;
    i_reset = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(d, "async o_valid", 32'(o_valid[d]), 32'd0);
      chk(d, "async o_pc", o_pc[d], 32'd0);
      chk(d, "async o_instr", o_instr[d], NOP);
      chk(d, "async o_stall_cnt", 32'(o_stall_cnt[d]), 32'd0);
    end
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    idle(2, 1'b1);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
    end
    idle(4, 1'b1);
    @(negedge i_clk);
    #2;
    for (int d = 0; d < 2; d++) chk(d, "final occupancy", 32'(sb[d].size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
